// File: rtl/psum_accum_wb.sv
// Partial-sum accumulator: read-modify-write of corelet psum beats into a
// 2-port psum SRAM over len_kij kernel passes, with optional final ReLU.
module psum_accum_wb #(
    parameter int psum_bw    = 16,
    parameter int col        = 8,
    parameter int addr_width = 8,
    parameter int len_onij   = 16,
    parameter int len_kij    = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic [addr_width-1:0]         base_addr_i,
    input  logic                          relu_en_i,
    input  logic                          d_valid_i,
    input  logic [col*psum_bw-1:0]        data_i,
    output logic                          rd_en_o,
    output logic [addr_width-1:0]         rd_addr_o,
    input  logic [col*psum_bw-1:0]        rd_data_i,
    output logic                          wr_en_o,
    output logic [addr_width-1:0]         wr_addr_o,
    output logic [col*psum_bw-1:0]        wr_data_o,
    output logic                          busy_o,
    output logic [$clog2(len_kij):0]      pass_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int OW = $clog2(len_onij);
    localparam int PW = $clog2(len_kij) + 1;
    localparam int DW = col * psum_bw;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [OW-1:0]           onij_q, onij_d;
    logic [PW-1:0]           kij_q, kij_d;
    logic                    err_q, err_d;
    logic [addr_width-1:0]   base_q;
    logic                    relu_q;

    logic                    s1_vld_q;
    logic [DW-1:0]           s1_data_q;
    logic [addr_width-1:0]   s1_addr_q;
    logic                    s1_first_q;
    logic                    s1_last_q;

    logic                    s2_vld_q;
    logic [addr_width-1:0]   wr_addr_q;
    logic [DW-1:0]           wr_data_q;
    logic [addr_width-1:0]   rd_addr_q;

    logic                    accept;
    logic                    first_pass;
    logic                    last_pass;
    logic                    last_beat;
    logic [addr_width-1:0]   beat_addr;
    logic [DW-1:0]           res_d;

    assign accept     = d_valid_i && (state_q == ACCUM);
    assign first_pass = (kij_q == '0);
    assign last_pass  = (kij_q == PW'(len_kij - 1));
    assign last_beat  = (onij_q == OW'(len_onij - 1));
    assign beat_addr  = base_q + addr_width'(onij_q);

    // The first pass needs no read: its value is simply the incoming beat
    assign rd_en_o   = accept && !first_pass;
    assign rd_addr_o = rd_en_o ? beat_addr : rd_addr_q;
    assign wr_en_o   = s2_vld_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = (state_q == ACCUM) || (state_q == DRAIN);
    assign done_o    = (state_q == DONE);
    assign pass_o    = kij_q;
    assign err_o     = err_q;

    // Control FSM, beat counters and sticky stray-beat error
    always_comb begin
        state_d = state_q;
        onij_d  = onij_q;
        kij_d   = kij_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ACCUM;
                    onij_d  = '0;
                    kij_d   = '0;
                    err_d   = 1'b0;
                end else if (d_valid_i) begin
                    err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (last_beat) begin
                        onij_d = '0;
                        if (last_pass) state_d = DRAIN;
                        else           kij_d   = kij_q + PW'(1);
                    end else begin
                        onij_d = onij_q + OW'(1);
                    end
                end
            end
            DRAIN: begin
                if (d_valid_i) err_d = 1'b1;
                if (s2_vld_q && !s1_vld_q) state_d = DONE;
            end
            DONE: begin
                if (d_valid_i) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and tile configuration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            onij_q  <= '0;
            kij_q   <= '0;
            err_q   <= 1'b0;
            base_q  <= '0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            onij_q  <= onij_d;
            kij_q   <= kij_d;
            err_q   <= err_d;
            if (state_q == IDLE && start_i) begin
                base_q <= base_addr_i;
                relu_q <= relu_en_i;
            end
        end
    end

    // Per-lane signed saturating add, then ReLU on the final pass
    always_comb begin
        logic signed [psum_bw:0]   wide;
        logic signed [psum_bw-1:0] a;
        logic signed [psum_bw-1:0] b;
        logic signed [psum_bw-1:0] r;
        wide  = '0;
        a     = '0;
        b     = '0;
        r     = '0;
        res_d = '0;
        for (int i = 0; i < col; i++) begin
            a    = s1_data_q[psum_bw*i +: psum_bw];
            b    = rd_data_i[psum_bw*i +: psum_bw];
            wide = {a[psum_bw-1], a} + {b[psum_bw-1], b};
            if (s1_first_q) begin
                r = a;
            end else if (wide[psum_bw] != wide[psum_bw-1]) begin
                r = wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                  : {1'b0, {(psum_bw-1){1'b1}}};
            end else begin
                r = wide[psum_bw-1:0];
            end
            if (s1_last_q && relu_q && r[psum_bw-1]) r = '0;
            res_d[psum_bw*i +: psum_bw] = r;
        end
    end

    // Read stage latch and write-back stage registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            s1_addr_q  <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_data_q  <= data_i;
                s1_addr_q  <= beat_addr;
                s1_first_q <= first_pass;
                s1_last_q  <= last_pass;
            end
            if (rd_en_o) rd_addr_q <= beat_addr;
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                wr_addr_q <= s1_addr_q;
                wr_data_q <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_wb.sv
// Scoreboard bench for psum_accum_wb: one instance with a single kernel
// pass (A) and one with two passes (B), each backed by an SRAM model.
module tb_psum_accum_wb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         a_start, a_relu, a_dv, a_rd_en, a_wr_en;
    logic         a_busy, a_done, a_err;
    logic [7:0]   a_base, a_rd_addr, a_wr_addr;
    logic [127:0] a_data, a_rd_data, a_wr_data;
    logic [0:0]   a_pass;

    logic         b_start, b_relu, b_dv, b_rd_en, b_wr_en;
    logic         b_busy, b_done, b_err;
    logic [7:0]   b_base, b_rd_addr, b_wr_addr;
    logic [127:0] b_data, b_rd_data, b_wr_data;
    logic [1:0]   b_pass;

    psum_accum_wb #(.len_kij(1)) u_a (
        .clk(clk), .reset(rst_n), .start_i(a_start),
        .base_addr_i(a_base), .relu_en_i(a_relu),
        .d_valid_i(a_dv), .data_i(a_data),
        .rd_en_o(a_rd_en), .rd_addr_o(a_rd_addr), .rd_data_i(a_rd_data),
        .wr_en_o(a_wr_en), .wr_addr_o(a_wr_addr), .wr_data_o(a_wr_data),
        .busy_o(a_busy), .pass_o(a_pass), .done_o(a_done), .err_o(a_err)
    );

    psum_accum_wb #(.len_kij(2)) u_b (
        .clk(clk), .reset(rst_n), .start_i(b_start),
        .base_addr_i(b_base), .relu_en_i(b_relu),
        .d_valid_i(b_dv), .data_i(b_data),
        .rd_en_o(b_rd_en), .rd_addr_o(b_rd_addr), .rd_data_i(b_rd_data),
        .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data),
        .busy_o(b_busy), .pass_o(b_pass), .done_o(b_done), .err_o(b_err)
    );

    logic [127:0] mem_a [256];
    logic [127:0] mem_b [256];

    always @(posedge clk) begin
        if (a_wr_en) mem_a[a_wr_addr] <= a_wr_data;
        if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
        if (b_wr_en) mem_b[b_wr_addr] <= b_wr_data;
        if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
    end

    typedef struct {
        logic [7:0]   addr;
        logic [127:0] data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  ncmp = 0;
    int  nfail = 0;
    int  a_rd_seen = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_rd_en) a_rd_seen++;
        if (a_wr_en) begin
            wr_t e;
            if (qa.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL a_stray_write: got addr %h want none", a_wr_addr);
            end else begin
                e = qa.pop_front();
                chk("a_wr_addr", 128'(a_wr_addr), 128'(e.addr));
                chk("a_wr_data", a_wr_data, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (b_wr_en) begin
            wr_t e;
            if (qb.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL b_stray_write: got addr %h want none", b_wr_addr);
            end else begin
                e = qb.pop_front();
                chk("b_wr_addr", 128'(b_wr_addr), 128'(e.addr));
                chk("b_wr_data", b_wr_data, e.data);
            end
        end
    end

    task automatic wait_done(input bit sel_b);
        int k;
        k = 1;
        while (!(sel_b ? b_done : a_done) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(sel_b ? "b_done_lat" : "a_done_lat", 128'(k), 128'd3);
        @(posedge clk);
        #1;
        chk(sel_b ? "b_done_pulse" : "a_done_pulse",
            sel_b ? {b_done, b_busy} : {a_done, a_busy}, 128'd0);
    endtask

    task automatic start_b(input logic [7:0] base, input logic relu);
        b_start = 1'b1;
        b_base  = base;
        b_relu  = relu;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        chk("b_busy_err", {b_busy, b_err}, 128'b10);
    endtask

    task automatic run_b(input logic [7:0] base, input logic relu,
                         input logic [127:0] d0, input logic [127:0] d1,
                         input logic [127:0] e1);
        logic [7:0] ad;
        start_b(base, relu);
        for (int p = 0; p < 2; p++) begin
            chk("b_pass", 128'(b_pass), 128'(p));
            for (int i = 0; i < 16; i++) begin
                ad = base + 8'(i);
                qb.push_back('{ad, (p == 0) ? d0 : e1});
                b_dv   = 1'b1;
                b_data = (p == 0) ? d0 : d1;
                #1;
                chk("b_rd_en", 128'(b_rd_en), 128'(p));
                if (p == 1) chk("b_rd_addr", 128'(b_rd_addr), 128'(ad));
                @(posedge clk);
                #1;
            end
        end
        b_dv = 1'b0;
        wait_done(1'b1);
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 0; a_relu = 0; a_dv = 0; a_base = 0; a_data = 0;
        b_start = 0; b_relu = 0; b_dv = 0; b_base = 0; b_data = 0;
        #1;
        chk("a_reset", {a_rd_en, a_rd_addr, a_wr_en, a_wr_addr,
                        a_busy, a_pass, a_done, a_err}, 128'd0);
        chk("b_reset", {b_rd_en, b_rd_addr, b_wr_en, b_wr_addr,
                        b_busy, b_pass, b_done, b_err}, 128'd0);
        chk("b_reset_wdata", b_wr_data, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single pass: plain copy, no reads
        a_start = 1'b1;
        a_base  = 8'h10;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_data = {16'h8000, {6{16'h00A5}}, 16'(i)};
            qa.push_back('{8'h10 + 8'(i), a_data});
            a_dv = 1'b1;
            @(posedge clk);
            #1;
        end
        a_dv = 1'b0;
        wait_done(1'b0);

        // reset at beat 5 of a tile: beats 0..2 already written
        start_b(8'h40, 1'b0);
        for (int i = 0; i < 5; i++) begin
            b_data = 128'(i + 1);
            if (i < 3) qb.push_back('{8'h40 + 8'(i), b_data});
            b_dv = 1'b1;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("b_midreset", {b_rd_en, b_rd_addr, b_wr_en, b_wr_addr,
                           b_busy, b_pass, b_done, b_err}, 128'd0);
        @(posedge clk);
        #1;
        chk("b_midreset_wr", 128'(b_wr_en), 128'd0);
        b_dv  = 1'b0;
        rst_n = 1'b1;
        chk("b_midreset_q", 128'(qb.size()), 128'd0);
        @(posedge clk);
        #1;

        // stray beat in IDLE
        chk("b_err_idle", 128'(b_err), 128'd0);
        b_dv   = 1'b1;
        b_data = {8{16'h1111}};
        #1;
        chk("b_stray_rd", 128'(b_rd_en), 128'd0);
        @(posedge clk);
        #1;
        b_dv = 1'b0;
        chk("b_err_set", 128'(b_err), 128'd1);
        repeat (3) @(posedge clk);
        #1;

        // two-pass add, base wraps past 0xFF; start clears err
        run_b(8'hF8, 1'b0, {8{16'h0003}}, {8{16'h0003}}, {8{16'h0006}});

        // saturation both directions
        run_b(8'h20, 1'b0,
              {{6{16'h0001}}, 16'h8010, 16'h7FF0},
              {{6{16'h0002}}, 16'hFFD0, 16'h0020},
              {{6{16'h0003}}, 16'h8000, 16'h7FFF});

        // ReLU on final pass only
        run_b(8'h60, 1'b1,
              {{3{16'h0005}}, 16'h0007, 16'hFFFB, {3{16'h0005}}},
              {{3{16'hFFF0}}, 16'h0000, 16'h0000, {3{16'hFFF0}}},
              {{3{16'h0000}}, 16'h0007, 16'h0000, {3{16'h0000}}});

        // same vectors without ReLU keep negatives
        run_b(8'h80, 1'b0,
              {{3{16'h0005}}, 16'h0007, 16'hFFFB, {3{16'h0005}}},
              {{3{16'hFFF0}}, 16'h0000, 16'h0000, {3{16'hFFF0}}},
              {{3{16'hFFF5}}, 16'h0007, 16'hFFFB, {3{16'hFFF5}}});

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_empty", 128'(qa.size()), 128'd0);
        chk("b_queue_empty", 128'(qb.size()), 128'd0);
        chk("a_no_reads", 128'(a_rd_seen), 128'd0);
        chk("b_err_end", 128'(b_err), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
